// File: rtl/psram_arb_ctrl.sv
// Two-port round-robin controller for the external PSRAM (single-lane SPI mode 0).
// Issues the PSRAM reset sequence after power-up, then serves 32-bit word reads/writes.
module psram_arb_ctrl #(
    parameter int DIV       = 1,
    parameter int INIT_WAIT = 7200,
    parameter int CS_GAP    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [31:0] wdat0,
    input  logic [31:0] wdat1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdat,
    output logic        ready,
    output logic        busy,
    input  logic        spi0_miso,
    output logic        spi0_sclk,
    output logic        spi0_cs0,
    output logic        spi0_mosi
);

    // state     | meaning
    // S_WAIT    | power-up wait, INIT_WAIT cycles
    // S_RSTEN   | 8-bit reset-enable frame (0x66)
    // S_GAP_EN  | CS high between reset-enable and reset
    // S_RST     | 8-bit reset frame (0x99)
    // S_GAP_RST | CS high after reset; enters IDLE with ready set
    // S_IDLE    | arbitrate and grant a request
    // S_XFER    | 64-bit command/address/data frame
    // S_GAP     | CS high after a transfer
    typedef enum logic [2:0] {
        S_WAIT, S_RSTEN, S_GAP_EN, S_RST, S_GAP_RST, S_IDLE, S_XFER, S_GAP
    } state_t;

    localparam int TW = $clog2(INIT_WAIT + CS_GAP + DIV + 1);
    localparam logic [7:0] CMD_RD    = 8'h03;
    localparam logic [7:0] CMD_WR    = 8'h02;
    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [5:0]      bit_cnt, bit_cnt_nxt;
    logic [63:0]     tx, tx_nxt;
    logic [30:0]     rx, rx_nxt;
    logic            x_we, x_we_nxt;
    logic            x_port, x_port_nxt;
    logic            last, last_nxt;
    logic            cs_nxt, sclk_nxt, mosi_nxt;
    logic            ack0_nxt, ack1_nxt;
    logic [31:0]     rdat_nxt;
    logic            ready_nxt, busy_nxt;

    logic            pick;
    logic            sel_we;
    logic [23:0]     sel_addr;
    logic [31:0]     sel_wdat;
    logic [63:0]     xfer_frame;
    logic            load;
    logic [63:0]     load_frame;
    logic [5:0]      load_bits;

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx;
        rx_nxt      = rx;
        x_we_nxt    = x_we;
        x_port_nxt  = x_port;
        last_nxt    = last;
        cs_nxt      = spi0_cs0;
        sclk_nxt    = spi0_sclk;
        mosi_nxt    = spi0_mosi;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        rdat_nxt    = rdat;
        ready_nxt   = ready;
        load        = 1'b0;
        load_frame  = '0;
        load_bits   = '0;

        // With both ports requesting, the one not served last wins.
        pick       = (req0 && req1) ? ~last : req1;
        sel_we     = pick ? we1 : we0;
        sel_addr   = pick ? addr1 : addr0;
        sel_wdat   = pick ? wdat1 : wdat0;
        xfer_frame = {sel_we ? CMD_WR : CMD_RD, sel_addr, sel_we ? sel_wdat : 32'h0};

        case (state)
            S_WAIT: begin
                if (tmr == '0) begin
                    load       = 1'b1;
                    load_frame = {CMD_RSTEN, 56'h0};
                    load_bits  = 6'd7;
                    state_nxt  = S_RSTEN;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_GAP_EN: begin
                if (tmr == '0) begin
                    load       = 1'b1;
                    load_frame = {CMD_RST, 56'h0};
                    load_bits  = 6'd7;
                    state_nxt  = S_RST;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_GAP_RST: begin
                if (tmr == '0) begin
                    state_nxt = S_IDLE;
                    ready_nxt = 1'b1;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_GAP: begin
                if (tmr == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_IDLE: begin
                if (req0 || req1) begin
                    load       = 1'b1;
                    load_frame = xfer_frame;
                    load_bits  = 6'd63;
                    last_nxt   = pick;
                    x_port_nxt = pick;
                    x_we_nxt   = sel_we;
                    state_nxt  = S_XFER;
                end
            end
            S_RSTEN, S_RST, S_XFER: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - TW'(1);
                end else if (!spi0_sclk) begin
                    sclk_nxt = 1'b1;
                    tmr_nxt  = TW'(DIV - 1);
                end else begin
                    // Falling SCLK edge: sample MISO, then either end the frame or present the next bit.
                    sclk_nxt = 1'b0;
                    rx_nxt   = {rx[29:0], spi0_miso};
                    if (bit_cnt == '0) begin
                        cs_nxt   = 1'b1;
                        mosi_nxt = 1'b0;
                        tmr_nxt  = TW'(CS_GAP - 1);
                        if (state == S_RSTEN) begin
                            state_nxt = S_GAP_EN;
                        end else if (state == S_RST) begin
                            state_nxt = S_GAP_RST;
                        end else begin
                            state_nxt = S_GAP;
                            ack0_nxt  = ~x_port;
                            ack1_nxt  = x_port;
                            if (!x_we) begin
                                rdat_nxt = {rx, spi0_miso};
                            end
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt - 6'd1;
                        mosi_nxt    = tx[63];
                        tx_nxt      = {tx[62:0], 1'b0};
                        tmr_nxt     = TW'(DIV - 1);
                    end
                end
            end
            default: state_nxt = S_WAIT;
        endcase

        if (load) begin
            cs_nxt      = 1'b0;
            sclk_nxt    = 1'b0;
            mosi_nxt    = load_frame[63];
            tx_nxt      = {load_frame[62:0], 1'b0};
            bit_cnt_nxt = load_bits;
            tmr_nxt     = TW'(DIV - 1);
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_WAIT;
            tmr       <= TW'(INIT_WAIT - 1);
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            x_we      <= 1'b0;
            x_port    <= 1'b0;
            last      <= 1'b1;
            spi0_cs0  <= 1'b1;
            spi0_sclk <= 1'b0;
            spi0_mosi <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdat      <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx        <= tx_nxt;
            rx        <= rx_nxt;
            x_we      <= x_we_nxt;
            x_port    <= x_port_nxt;
            last      <= last_nxt;
            spi0_cs0  <= cs_nxt;
            spi0_sclk <= sclk_nxt;
            spi0_mosi <= mosi_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            rdat      <= rdat_nxt;
            ready     <= ready_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: doc/psram_arb_ctrl.md
# psram_arb_ctrl

Two-port arbitrated controller for the external PSRAM on the `spi0_*` pins. It performs the power-up reset sequence, then serves 32-bit single-word read/write requests from two requesters (port 0: SPI-slave register bridge, port 1: on-chip test/pattern engine) using round-robin arbitration. It drives single-lane SPI mode 0 (commands 0x03 read, 0x02 write, 24-bit address) in the 48 MHz `clk` domain. The top level continues to tie `spi0_nwp`/`spi0_nhld` high.

## Interface
- `DIV`, 1: SCLK half-period in `clk` cycles (1 → 24 MHz SCLK); legal 1..15.
- `INIT_WAIT`, 7200: power-up wait in `clk` cycles before the reset commands (150 µs at 48 MHz).
- `CS_GAP`, 3: minimum `spi0_cs0`-high cycles between any two frames.
- `clk` in 1: 48 MHz system clock.
- `reset` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: request; held high until the matching ack.
- `we0`, `we1` in 1: 1 = write, 0 = read; stable while req high.
- `addr0`, `addr1` in 24: byte address; stable while req high.
- `wdat0`, `wdat1` in 32: write data; stable while req high.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdat` out 32: read data (shared); valid in the ack cycle; held until the next read completes.
- `ready` out 1: high once the init sequence is done.
- `busy` out 1: high whenever state ≠ IDLE.
- `spi0_miso` in 1: PSRAM data out.
- `spi0_sclk` out 1: SPI clock; idles low.
- `spi0_cs0` out 1: chip select, active low.
- `spi0_mosi` out 1: PSRAM data in.

## Operation
- All outputs are registered. Reset values: `spi0_cs0`=1, `spi0_sclk`=0, `spi0_mosi`=0, `ack0`=`ack1`=0, `rdat`=0, `ready`=0, `busy`=1. The round-robin pointer resets to favour port 0.
- States: WAIT → RSTEN → GAP → RST → GAP → IDLE; IDLE → XFER → GAP → IDLE.
- WAIT: count `INIT_WAIT` cycles, then go to RSTEN.
- RSTEN/RST: send an 8-bit frame, 0x66 then 0x99. `ready` rises on entry to IDLE after the post-RST gap.
- IDLE: if exactly one req is high, grant it. If both are high, grant the port not served last. Latch `we`, `addr`, `wdat` and the port id in the grant cycle.
- XFER frame: 64 bits MSB-first = {cmd[7:0], addr[23:0], data[31:0]}. Read frames send 0x00 in the data field.
- Per bit: drive `spi0_mosi`, hold `spi0_sclk` low for DIV cycles, then high for DIV cycles.
- `spi0_miso` is sampled on the `clk` edge that drives SCLK low again. During read frames, only the last 32 bits shift into `rdat`, MSB first.
- Frame end: in the same cycle, `spi0_cs0` goes to 1 and `spi0_sclk` stays 0. The granted port's ack pulses and `rdat` updates (reads only). Go to GAP.
- GAP: hold `spi0_cs0` high for `CS_GAP` cycles, then return to IDLE. In IDLE, a request can be granted in the first cycle.
- Requests arriving before `ready` stay pending and are not acked. They are served in round-robin order once `ready` is high.
- A req dropped after grant does not abort the frame; the ack still pulses.
- A write's ack does not change `rdat`.
- Address wrap is not handled; the PSRAM wraps internally.
- Reset asserted mid-frame: all outputs return to reset values next cycle (CS releases immediately), no ack is issued, and the block restarts at WAIT.

## Timing
- Grant cycle = T. `spi0_cs0` falls at T+1 with bit 63 on `spi0_mosi`.
- XFER lasts 128·DIV cycles. Ack, CS rise and `rdat` update all occur at T+1+128·DIV.
- Earliest next grant: T+1+128·DIV+`CS_GAP`. For DIV=1, `CS_GAP`=3, back-to-back requests: 132-cycle period per word.
- Init frames last 16·DIV cycles of CS low each. `ready` rises at `INIT_WAIT`+2·(16·DIV+`CS_GAP`)+1 cycles (±1) after reset deasserts.
- Each ack is exactly one cycle wide. `ack0` and `ack1` are never high together.

## Test plan
- Reset release, no requests → after 7200 cycles, MOSI shows 0x66 then 0x99 in two separate CS-low frames of 8 SCLK rising edges each. `ready`=1 at ~7239 cycles (DIV=1).
- Port 0 writes addr 0x012345, data 0xDEADBEEF → MOSI frame 0x02_012345_DEADBEEF. `ack0` at grant+129. `rdat` unchanged.
- Port 1 reads addr 0x012345, PSRAM model returns 0xDEADBEEF → MOSI 0x03_012345_00000000. `ack1` at grant+129 with `rdat`=0xDEADBEEF.
- `req0` and `req1` held high continuously → grants alternate 0,1,0,1. Ack spacing is 132 cycles. No ack overlap; CS high ≥3 cycles between frames.
- `req1` raised during init → no ack before `ready`. First transaction after `ready` goes to port 1 and completes normally.
- `reset` pulsed at bit 20 of a read → CS high, SCLK low, no ack the next cycle. WAIT restarts with the init sequence reissued. `rdat`=0.
